gpio_display_io: RTL and testbench

Board-side peer of the CPU's GPIO port: drives the CPU's `gpio_in` and consumes its `gpio_out`.

- **Input path:** synchronizes and debounces 18 slide switches into `gpio_in`.
- **Output path:** watches `gpio_out`, converts it to decimal with a sequential shift-add-3 (double-dabble) engine, and drives eight active-low seven-segment displays.
- **Placement:** sits at top level between the board pins and the `cpu` instance.

---
 rtl/gpio_display_io.sv | 187 ++++++++++++++++++
 tb/tb_gpio_display_io.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_display_io.sv
// Board-side GPIO peer: debounced switches into gpio_in, gpio_out shown in decimal on eight 7-seg displays.
// Optional leading-zero blanking when GPIO_IO_BLANK_EN is defined.
module gpio_display_io #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] sw,
  input  logic [31:0] gpio_out,
  output logic [31:0] gpio_in,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic        busy
);

  localparam int unsigned SW_W   = 18;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BIN_W  = 32;
  localparam int unsigned BCD_W  = 40;
  localparam int unsigned SR_W   = BIN_W + BCD_W;
  localparam int unsigned ITER_W = 6;
  localparam int unsigned NDIG   = 10;
  localparam int unsigned NHEX   = 8;

  localparam logic [CNT_W-1:0]  TICK_TOP  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BIN_W - 1);
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
`ifdef GPIO_IO_BLANK_EN
  localparam logic [NHEX-1:0][6:0] HEX_RESET = {{(NHEX-1){SEG_BLANK}}, SEG_0};
`else
  localparam logic [NHEX-1:0][6:0] HEX_RESET = {NHEX{SEG_0}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_LOAD} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  logic [SW_W-1:0]  r_sync1, r_sync2, r_samp, r_stable;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic [SW_W-1:0]  w_agree;

  state_t           r_state, w_next_state;
  logic             w_start;
  logic [BIN_W-1:0] r_value;
  logic [SR_W-1:0]  r_shift, w_adj;
  logic [ITER_W-1:0] r_iter;
  logic             r_busy;
  logic [BCD_W-1:0] w_bcd;
  logic [NHEX-1:0][6:0] r_hex, w_hex;
`ifdef GPIO_IO_BLANK_EN
  logic             w_nz;
`endif

  assign w_tick  = (r_tick_cnt == TICK_TOP);
  assign w_agree = ~(r_sync2 ^ r_samp);

  // Synchronizer, shared tick, and two-tick agreement filter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_samp     <= '0;
      r_stable   <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
      if (w_tick) begin
        r_tick_cnt <= '0;
        r_samp     <= r_sync2;
        r_stable   <= (r_sync2 & w_agree) | (r_stable & ~w_agree);
      end else begin
        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
      end
    end
  end

  assign gpio_in = {14'd0, r_stable};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (gpio_out != r_value) begin
          w_start      = 1'b1;
          w_next_state = S_CONVERT;
        end
      end
      S_CONVERT: if (r_iter == ITER_LAST) w_next_state = S_LOAD;
      S_LOAD:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Double-dabble correction: +3 on every BCD nibble >= 5 ahead of the shift
  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < NDIG; i++) begin
      if (r_shift[BIN_W + 4*i +: 4] >= 4'd5)
        w_adj[BIN_W + 4*i +: 4] = r_shift[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  assign w_bcd = r_shift[SR_W-1:BIN_W];

  // Digit encode with overflow dashes and optional leading-zero blanking
  always_comb begin
    w_hex = '0;
`ifdef GPIO_IO_BLANK_EN
    w_nz  = 1'b0;
    for (int k = NHEX - 1; k >= 0; k--) begin
      w_nz     = w_nz | (w_bcd[k*4 +: 4] != 4'd0);
      w_hex[k] = (k == 0 || w_nz) ? seg7(w_bcd[k*4 +: 4]) : SEG_BLANK;
    end
`else
    for (int k = 0; k < NHEX; k++) w_hex[k] = seg7(w_bcd[k*4 +: 4]);
`endif
    if (|w_bcd[BCD_W-1:NHEX*4]) w_hex = {NHEX{SEG_DASH}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= '0;
      r_shift <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_hex   <= HEX_RESET;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_value <= gpio_out;
            r_shift <= {{BCD_W{1'b0}}, gpio_out};
            r_iter  <= '0;
          end
        end
        S_CONVERT: begin
          r_shift <= w_adj << 1;
          r_iter  <= r_iter + ITER_W'(1);
        end
        S_LOAD:  r_hex <= w_hex;
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign hex0 = r_hex[0];
  assign hex1 = r_hex[1];
  assign hex2 = r_hex[2];
  assign hex3 = r_hex[3];
  assign hex4 = r_hex[4];
  assign hex5 = r_hex[5];
  assign hex6 = r_hex[6];
  assign hex7 = r_hex[7];

endmodule

// File: tb/tb_gpio_display_io.sv
// Scoreboard bench for gpio_display_io with DEBOUNCE_CYCLES = 4; honours GPIO_IO_BLANK_EN.
module tb_gpio_display_io;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sw;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        busy;
  logic [55:0] hex_all;

  int n_checks = 0;
  int n_fail   = 0;
  int last_edges;
  bit last_first_busy;
  logic [55:0] sb[$];

`ifdef GPIO_IO_BLANK_EN
  localparam logic [55:0] RST_HEX = {{7{7'h7F}}, 7'h40};
  localparam logic [6:0]  UPPER_ZERO = 7'h7F;
`else
  localparam logic [55:0] RST_HEX = {8{7'h40}};
  localparam logic [6:0]  UPPER_ZERO = 7'h40;
`endif

  gpio_display_io #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7), .busy(busy)
  );

  assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  // Reference display for a value, built from integer division
  function automatic logic [55:0] model_hex(input logic [31:0] v);
    logic [55:0] r;
    longint p;
    int d;
    bit shown;
    r = '0;
    p = 1;
    if (v > 32'd99999999) return {8{7'h3F}};
    for (int k = 0; k < 8; k++) begin
      d = int'((longint'(v) / p) % 10);
      shown = (k == 0) || (longint'(v) >= p);
`ifdef GPIO_IO_BLANK_EN
      r[k*7 +: 7] = shown ? ref_seg(d) : 7'h7F;
`else
      r[k*7 +: 7] = ref_seg(d);
`endif
      p = p * 10;
    end
    return r;
  endfunction

  task automatic drive_value(input logic [31:0] v, input bit expect_display);
    gpio_out = v;
    if (expect_display) sb.push_back(model_hex(v));
  endtask

  // Wait for a conversion to finish, then score busy length and display
  task automatic wait_done(input string tag);
    int busy_cycles = 0;
    int edges = 0;
    bit seen = 0;
    bit done = 0;
    logic [55:0] exp_hex;
    last_first_busy = 0;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) last_first_busy = busy;
      if (busy) begin busy_cycles++; seen = 1; end
      else if (seen) done = 1;
    end
    last_edges = edges;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%0b after %0d edges, required conversion done", tag, busy, edges);
      return;
    end
    n_checks++;
    if (busy_cycles !== 33) begin
      n_fail++;
      $display("FAIL %s_busy_len: got %0d cycles, required 33", tag, busy_cycles);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: no expected entry queued", tag);
    end else begin
      exp_hex = sb.pop_front();
      if (hex_all !== exp_hex) begin
        n_fail++;
        $display("FAIL %s_hex: got %h, required %h", tag, hex_all, exp_hex);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; sw = '0; gpio_out = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (gpio_in !== 32'd0) begin n_fail++; $display("FAIL rst_gpio_in: got %h, required 0", gpio_in); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_checks++;
    if (hex0 !== 7'h40) begin n_fail++; $display("FAIL rst_hex0: got %h, required 40", hex0); end
    n_checks++;
    if (hex_all !== RST_HEX) begin n_fail++; $display("FAIL rst_hex_all: got %h, required %h", hex_all, RST_HEX); end
    @(negedge clk);
    drive_value(32'd999, 0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b, required 1", busy); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_async: got %b, required 0", busy); end
    n_checks++;
    if (hex_all !== RST_HEX) begin n_fail++; $display("FAIL abort_hex: got %h, required %h", hex_all, RST_HEX); end
    n_checks++;
    if (gpio_in !== 32'd0) begin n_fail++; $display("FAIL abort_gpio_in: got %h, required 0", gpio_in); end
    gpio_out = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_debounce();
    bit changed = 0;
    logic [31:0] seen_bad = '0;
    sw = 18'h2A5A5;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (gpio_in !== 32'h0002A5A5) begin n_fail++; $display("FAIL debounce_accept: got %h, required 0002a5a5", gpio_in); end
    @(negedge clk); sw[0] = 1'b0;
    @(negedge clk); sw[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (gpio_in !== 32'h0002A5A5) begin changed = 1; seen_bad = gpio_in; end
    end
    n_checks++;
    if (changed) begin n_fail++; $display("FAIL debounce_glitch: got %h, required 0002a5a5", seen_bad); end
  endtask

  task automatic test_convert();
    @(negedge clk);
    drive_value(32'd12345678, 1);
    wait_done("convert");
    n_checks++;
    if (last_edges !== 34) begin n_fail++; $display("FAIL convert_latency: got %0d edges, required 34", last_edges); end
    n_checks++;
    if (hex_all !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}) begin
      n_fail++; $display("FAIL convert_digits: got %h, required 12345678 pattern", hex_all);
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    drive_value(32'd100000000, 1);
    wait_done("overflow");
    n_checks++;
    if (hex_all !== {8{7'h3F}}) begin n_fail++; $display("FAIL overflow_dash: got %h, required all 3f", hex_all); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_value(32'd5, 1);
    fork
      begin
        repeat (10) @(negedge clk);
        drive_value(32'd42, 1);
      end
      wait_done("coalesce_first");
    join
    wait_done("coalesce_second");
    n_checks++;
    if (last_first_busy !== 1'b1) begin n_fail++; $display("FAIL coalesce_gap: busy=%b on first edge after done, required 1", last_first_busy); end
    n_checks++;
    if (hex1 !== 7'h19) begin n_fail++; $display("FAIL coalesce_hex1: got %h, required 19", hex1); end
    n_checks++;
    if (hex0 !== 7'h24) begin n_fail++; $display("FAIL coalesce_hex0: got %h, required 24", hex0); end
  endtask

  task automatic test_blank();
    @(negedge clk);
    drive_value(32'd7, 1);
    wait_done("blank");
    n_checks++;
    if (hex0 !== 7'h78) begin n_fail++; $display("FAIL blank_hex0: got %h, required 78", hex0); end
    n_checks++;
    if ({hex7, hex6, hex5, hex4, hex3, hex2, hex1} !== {7{UPPER_ZERO}}) begin
      n_fail++; $display("FAIL blank_upper: got %h, required %h", {hex7, hex6, hex5, hex4, hex3, hex2, hex1}, {7{UPPER_ZERO}});
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_convert();
    test_overflow();
    test_back_to_back();
    test_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
